// File: rtl/priv_1_11_seq_pkg.sv
// Shared types and constants for the privileged redirect sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package priv_1_11_seq_pkg;

  // Architectural widths of the redirect datapath
  localparam int XLEN         = 32;
  localparam int MTVEC_BASE_W = 30;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } seq_state_t;

  // Which kind of redirect is in flight; decides target and commit strobe
  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } redirect_kind_t;

  // Word-aligned mtvec base address: the low two bits are implicit zeros
  function automatic logic [XLEN-1:0] mtvec_addr(input logic [MTVEC_BASE_W-1:0] base);
    return {base, 2'b00};
  endfunction

endpackage

// File: rtl/priv_1_11_trap_target.sv
// Redirect target calculation: mepc for mret, mtvec base (+4*cause when vectored irq) for traps.
// Latency: purely combinational, registered by the sequencer when draining ends.
// Backpressure: none; output follows inputs.
module priv_1_11_trap_target
  import priv_1_11_seq_pkg::*;
#(
  parameter int CAUSE_W = 5
) (
  input  redirect_kind_t          kind,
  input  logic                    vec,
  input  logic                    intr,
  input  logic [CAUSE_W-1:0]      cause,
  input  logic [MTVEC_BASE_W-1:0] base,
  input  logic [XLEN-1:0]         mepc,
  output logic [XLEN-1:0]         target
);

  // Zero-extend the cause into a word offset; a carry out of bit 31 is dropped
  localparam int PAD_W = XLEN - CAUSE_W - 2;

  logic [XLEN-1:0] base_addr;
  logic [XLEN-1:0] vec_off;

  assign base_addr = mtvec_addr(base);
  assign vec_off   = {{PAD_W{1'b0}}, cause, 2'b00};

  // Select return PC, vectored interrupt entry or common trap entry
  always_comb begin
    target = base_addr;
    if (kind == KIND_MRET) begin
      target = mepc;
    end else if (vec && intr) begin
      target = base_addr + vec_off;
    end
  end

endmodule

// File: rtl/priv_1_11_trap_sequencer.sv
// Sequences trap entry / mret: latch request, flush and drain pipe, hold redirect, pulse CSR commit.
// Latency: request -> insert_pc in 2 cycles minimum (pipe already clear), commit in the ack cycle.
// Backpressure: insert_pc/priv_pc held until fetch_ack; requests are levels held by the requester.
module priv_1_11_trap_sequencer
  import priv_1_11_seq_pkg::*;
#(
  parameter int CAUSE_W       = 5,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trap_req,
  input  logic                    trap_intr,
  input  logic [CAUSE_W-1:0]      trap_cause,
  input  logic                    mret_req,
  input  logic [MTVEC_BASE_W-1:0] mtvec_base,
  input  logic                    mtvec_vec,
  input  logic [XLEN-1:0]         mepc,
  input  logic                    pipe_clear,
  input  logic                    fetch_ack,
  output logic                    flush_req,
  output logic                    insert_pc,
  output logic [XLEN-1:0]         priv_pc,
  output logic                    trap_commit,
  output logic                    mret_commit,
  output logic                    busy,
  output logic                    drain_err
);

  // Counter only needs to reach DRAIN_TIMEOUT-1; the drain ends on that value
  localparam int              CNT_W    = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  seq_state_t     state, state_nxt;
  redirect_kind_t kind;
  logic           lat_intr;
  logic [CAUSE_W-1:0] lat_cause;
  logic [CNT_W-1:0]   drain_cnt;
  logic           pend;
  logic [XLEN-1:0] target;

  // Control strobes from the next-state logic to the datapath registers
  logic take_trap;
  logic take_mret;
  logic drain_exit;
  logic drain_tmo;

  priv_1_11_trap_target #(
    .CAUSE_W (CAUSE_W)
  ) u_target (
    .kind   (kind),
    .vec    (mtvec_vec),
    .intr   (lat_intr),
    .cause  (lat_cause),
    .base   (mtvec_base),
    .mepc   (mepc),
    .target (target)
  );

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, request arbitration and handshake outputs
  always_comb begin
    state_nxt   = state;
    flush_req   = 1'b0;
    insert_pc   = 1'b0;
    trap_commit = 1'b0;
    mret_commit = 1'b0;
    take_trap   = 1'b0;
    take_mret   = 1'b0;
    drain_exit  = 1'b0;
    drain_tmo   = 1'b0;
    unique case (state)
      IDLE: begin
        // Trap beats mret; a trap that arrived during an mret also
        // blocks mret for the single IDLE cycle after that mret commits
        if (trap_req) begin
          take_trap = 1'b1;
          state_nxt = DRAIN;
        end else if (mret_req && !pend) begin
          take_mret = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        flush_req = 1'b1;
        if (pipe_clear) begin
          drain_exit = 1'b1;
          state_nxt  = REDIRECT;
        end else if (drain_cnt == CNT_LAST) begin
          // Give up waiting, flag it, and redirect anyway
          drain_tmo  = 1'b1;
          drain_exit = 1'b1;
          state_nxt  = REDIRECT;
        end
      end
      REDIRECT: begin
        flush_req = 1'b1;
        insert_pc = 1'b1;
        if (fetch_ack) begin
          // CSR side effects happen exactly when fetch takes the target
          trap_commit = !rst && (kind == KIND_TRAP);
          mret_commit = !rst && (kind == KIND_MRET);
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, drain counter, target register and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      kind      <= KIND_TRAP;
      lat_intr  <= 1'b0;
      lat_cause <= '0;
      drain_cnt <= '0;
      priv_pc   <= '0;
      drain_err <= 1'b0;
      pend      <= 1'b0;
    end else begin
      if (take_trap) begin
        kind      <= KIND_TRAP;
        lat_intr  <= trap_intr;
        lat_cause <= trap_cause;
      end else if (take_mret) begin
        kind <= KIND_MRET;
      end

      // Counts cycles spent in DRAIN; restarts from zero for every sequence
      if (state == DRAIN && !drain_exit) begin
        drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
      end

      // Target is frozen on leaving DRAIN so it is stable while insert_pc is up
      if (drain_exit) begin
        priv_pc <= target;
      end

      if (drain_tmo) begin
        drain_err <= 1'b1;
      end

      // Remember a trap seen while an mret is in flight; consumed in IDLE
      if (state == IDLE) begin
        pend <= 1'b0;
      end else if (trap_req && kind == KIND_MRET) begin
        pend <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
